chip8_fetch: RTL and testbench
==============================

# chip8_fetch

Instruction fetch stage of the CHIP-8 core. Sits directly downstream of the 4096-byte program memory that the ROM loader fills from 0x200. Reads two consecutive bytes at the program counter over a synchronous single-port read interface and assembles a big-endian 16-bit opcode. Presents the opcode to the decoder over a valid/ready handshake, with a redirect port for jumps, calls, returns and skips.

## Interface
- START_ADDR, 12'h200: PC value loaded at reset; first opcode fetched.
- ADDR_W, 12: address width; memory depth is 2**ADDR_W bytes.
- clk_in  input  1  core clock; all state updates on rising edge.
- rst_in  input  1  reset, synchronous, active-high.
- start  input  1  level; fetching begins in the first cycle it is seen high after reset.
- mem_addr  output  ADDR_W  byte address to program memory.
- mem_rd_en  output  1  read strobe; data returns on mem_rd_data exactly one cycle later.
- mem_rd_data  input  8  byte read from the address strobed in the previous cycle.
- instr  output  16  fetched opcode, {byte[pc], byte[pc+1]}.
- instr_pc  output  ADDR_W  address of instr's high byte.
- instr_valid  output  1  instr/instr_pc valid; held stable until accepted.
- instr_ready  input  1  decoder accepts when instr_valid && instr_ready at a rising edge.
- redirect_valid  input  1  one-cycle pulse: discard in-flight work, refetch from redirect_pc.
- redirect_pc  input  ADDR_W  new PC, any value (odd allowed).

## Operation
- States: IDLE, HI, LO, CAP, OUT.
- IDLE: mem_rd_en=0, mem_addr=0, instr_valid=0. To HI when start=1.
- HI: mem_addr=pc, mem_rd_en=1. Always to LO.
- LO: mem_addr=pc+1 (mod 2**ADDR_W), mem_rd_en=1, hi_byte <= mem_rd_data. Always to CAP.
- CAP: mem_rd_en=0, instr <= {hi_byte, mem_rd_data}, instr_pc <= pc, instr_valid <= 1. Always to OUT.
- OUT: mem_rd_en=0, hold outputs. On instr_valid && instr_ready: instr_valid <= 0, pc <= pc+2 (mod 2**ADDR_W), to HI.
- Redirect has priority over every transition in HI/LO/CAP/OUT. At that edge, pc <= redirect_pc, instr_valid <= 0, state <= HI, and the byte in flight is dropped. In IDLE, redirect loads pc only; state stays IDLE until start.
- Redirect coincident with a handshake: the opcode counts as consumed, and pc takes redirect_pc, not pc+2.
- start is sampled only in IDLE; deasserting it later has no effect.
- PC arithmetic is ADDR_W bits, wrap-around silent: pc=0xFFF fetches bytes 0xFFF then 0x000, next pc=0x001.
- Reset: pc=START_ADDR, state=IDLE, hi_byte=0. Outputs: mem_addr=0, mem_rd_en=0, instr=0, instr_pc=0, instr_valid=0. Reset mid-fetch abandons all work without a further read strobe.

## Timing
- mem_addr and mem_rd_en are combinational from state/pc. instr, instr_pc and instr_valid are registered.
- Latency: HI entered at cycle N gives instr_valid=1 in cycle N+3.
- Throughput with ready held high: one opcode per 4 cycles (HI, LO, CAP, OUT).
- Redirect pulse at edge E: mem_addr=redirect_pc with rd_en=1 in the cycle after E; valid opcode 3 cycles after that.
- instr_valid never drops without a handshake, redirect or reset.

## Structure
- chip8_pkg (shared): typedef addr_t (logic [11:0]), typedef opcode_t (logic [15:0]), localparam PROG_START = 12'h200, fetch state enum.
- START_ADDR defaults to chip8_pkg::PROG_START.
- Single module, no sub-modules; FSM plus pc/hi_byte/output registers.

## Test plan
- Memory 0x200=0x12, 0x201=0x34, 0x202=0x60, 0x203=0x0A; reset, start=1, ready=1 -> opcodes 0x1234 @0x200, then 0x600A @0x202; valid 3 cycles after HI; one opcode every 4 cycles.
- Hold ready=0 for 10 cycles while valid -> instr/instr_pc stable, mem_rd_en=0 throughout; ready=1 -> single handshake, next fetch at 0x202.
- Redirect to 0x300 during LO of the fetch at 0x200 -> no opcode from 0x200 emitted; next opcode is {mem[0x300], mem[0x301]} with instr_pc=0x300.
- Redirect to 0x250 in the same edge as a handshake -> next fetch address 0x250, not 0x202.
- Redirect to 0xFFF, mem[0xFFF]=0xAB, mem[0x000]=0xCD -> opcode 0xABCD @0xFFF; next fetch at 0x001.
- Assert rst_in during CAP -> next cycle valid=0, rd_en=0, state IDLE; with start held, refetch from 0x200.

Source files
------------

// File: rtl/chip8_pkg.sv
// Shared CHIP-8 core types: address/opcode widths, program start address
// and the fetch-stage state encoding.
package chip8_pkg;

    typedef logic [11:0] addr_t;
    typedef logic [15:0] opcode_t;

    localparam addr_t PROG_START = 12'h200;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HI,
        ST_LO,
        ST_CAP,
        ST_OUT
    } fetch_state_t;

endpackage

// File: rtl/chip8_fetch.sv
// CHIP-8 instruction fetch: reads two bytes at pc from a synchronous memory,
// assembles a big-endian opcode and hands it to the decoder via valid/ready.
module chip8_fetch
    import chip8_pkg::*;
#(
    parameter int                ADDR_W     = 12,
    parameter logic [ADDR_W-1:0] START_ADDR = ADDR_W'(PROG_START)
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              start,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    input  logic [7:0]        mem_rd_data,
    output logic [15:0]       instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc
);

    fetch_state_t      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [7:0]        hi_byte_q, hi_byte_d;
    opcode_t           instr_q, instr_d;
    logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
    logic              instr_valid_q, instr_valid_d;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        hi_byte_d     = hi_byte_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        instr_valid_d = instr_valid_q;
        mem_addr      = '0;
        mem_rd_en     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (redirect_valid) pc_d = redirect_pc;
                if (start)          state_d = ST_HI;
            end
            ST_HI: begin
                mem_addr  = pc_q;
                mem_rd_en = 1'b1;
                state_d   = ST_LO;
            end
            ST_LO: begin
                mem_addr  = pc_q + ADDR_W'(1);
                mem_rd_en = 1'b1;
                hi_byte_d = mem_rd_data;
                state_d   = ST_CAP;
            end
            ST_CAP: begin
                instr_d       = {hi_byte_q, mem_rd_data};
                instr_pc_d    = pc_q;
                instr_valid_d = 1'b1;
                state_d       = ST_OUT;
            end
            ST_OUT: begin
                if (instr_valid_q && instr_ready) begin
                    instr_valid_d = 1'b0;
                    pc_d          = pc_q + ADDR_W'(2);
                    state_d       = ST_HI;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Redirect overrides everything once fetching; data still returning
        // from memory belongs to the old stream and must not land anywhere.
        if (redirect_valid && state_q != ST_IDLE) begin
            pc_d          = redirect_pc;
            hi_byte_d     = hi_byte_q;
            instr_d       = instr_q;
            instr_pc_d    = instr_pc_q;
            instr_valid_d = 1'b0;
            state_d       = ST_HI;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q       <= ST_IDLE;
            pc_q          <= START_ADDR;
            hi_byte_q     <= '0;
            instr_q       <= '0;
            instr_pc_q    <= '0;
            instr_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            hi_byte_q     <= hi_byte_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
        end
    end

    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = instr_valid_q;

endmodule

// File: tb/tb_chip8_fetch.sv
// Directed bench for chip8_fetch against a 4 KiB synchronous-read byte memory.
module tb_chip8_fetch;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        start;
    logic [11:0] mem_addr;
    logic        mem_rd_en;
    logic [7:0]  mem_rd_data;
    logic [15:0] instr;
    logic [11:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        redirect_valid;
    logic [11:0] redirect_pc;

    logic [7:0]  mem [0:4095];
    int          n_tests = 0;
    int          n_fail  = 0;

    chip8_fetch dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .start          (start),
        .mem_addr       (mem_addr),
        .mem_rd_en      (mem_rd_en),
        .mem_rd_data    (mem_rd_data),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) begin
        if (mem_rd_en) mem_rd_data <= mem[mem_addr];
    end

    task automatic step();
        @(negedge clk_in);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_op(input string tag, input logic [15:0] op, input logic [11:0] pc);
        chk({tag, "_valid"}, {31'd0, instr_valid}, 32'd1);
        chk({tag, "_instr"}, {16'd0, instr}, {16'd0, op});
        chk({tag, "_pc"},    {20'd0, instr_pc}, {20'd0, pc});
    endtask

    task automatic chk_rd(input string tag, input logic [11:0] addr);
        chk({tag, "_rden"}, {31'd0, mem_rd_en}, 32'd1);
        chk({tag, "_addr"}, {20'd0, mem_addr}, {20'd0, addr});
        chk({tag, "_vld0"}, {31'd0, instr_valid}, 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 8'(i) ^ 8'h5A;
        mem[12'h200] = 8'h12; mem[12'h201] = 8'h34;
        mem[12'h202] = 8'h60; mem[12'h203] = 8'h0A;
        mem[12'h204] = 8'hA2; mem[12'h205] = 8'hF0;
        mem[12'h300] = 8'h00; mem[12'h301] = 8'hE0;
        mem[12'h250] = 8'h3C; mem[12'h251] = 8'h01;
        mem[12'hFFF] = 8'hAB; mem[12'h000] = 8'hCD;
        mem_rd_data    = 8'h00;
        rst_in         = 1'b1;
        start          = 1'b0;
        instr_ready    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 12'h000;

        step(); step();
        chk("rst_rden",  {31'd0, mem_rd_en}, 32'd0);
        chk("rst_addr",  {20'd0, mem_addr}, 32'd0);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_instr", {16'd0, instr}, 32'd0);
        chk("rst_ipc",   {20'd0, instr_pc}, 32'd0);
        rst_in = 1'b0;
        step();
        chk("idle_rden", {31'd0, mem_rd_en}, 32'd0);

        // First fetch with decoder stalled
        start = 1'b1;
        step(); chk_rd("hi200", 12'h200);
        step(); chk_rd("lo201", 12'h201);
        step();
        chk("cap_rden",  {31'd0, mem_rd_en}, 32'd0);
        chk("cap_valid", {31'd0, instr_valid}, 32'd0);
        step(); chk_op("op200", 16'h1234, 12'h200);
        for (int i = 0; i < 10; i++) begin
            step();
            chk_op($sformatf("hold%0d", i), 16'h1234, 12'h200);
            chk($sformatf("hold%0d_rden", i), {31'd0, mem_rd_en}, 32'd0);
        end

        // Release ready: one handshake, then back-to-back fetches every 4 cycles
        instr_ready = 1'b1;
        step(); chk_rd("hi202", 12'h202);
        step(); step(); step(); chk_op("op202", 16'h600A, 12'h202);
        step(); chk_rd("hi204", 12'h204);
        step(); step(); step(); chk_op("op204", 16'hA2F0, 12'h204);
        step(); chk_rd("hi206", 12'h206);

        // Redirect in HI to 0x200, then again in LO to 0x300
        redirect_valid = 1'b1; redirect_pc = 12'h200;
        step(); redirect_valid = 1'b0;
        chk_rd("rd_hi200", 12'h200);
        step(); chk_rd("rd_lo201", 12'h201);
        redirect_valid = 1'b1; redirect_pc = 12'h300;
        step(); redirect_valid = 1'b0;
        chk_rd("rd_hi300", 12'h300);
        step(); chk_rd("rd_lo301", 12'h301);
        step(); chk("rd_cap_valid", {31'd0, instr_valid}, 32'd0);
        step(); chk_op("op300", 16'h00E0, 12'h300);

        // Redirect coincident with handshake
        redirect_valid = 1'b1; redirect_pc = 12'h250;
        step(); redirect_valid = 1'b0;
        chk_rd("hs_hi250", 12'h250);
        step(); step(); step(); chk_op("op250", 16'h3C01, 12'h250);

        // Wrap-around at top of memory
        redirect_valid = 1'b1; redirect_pc = 12'hFFF;
        step(); redirect_valid = 1'b0;
        chk_rd("wr_hiFFF", 12'hFFF);
        step(); chk_rd("wr_lo000", 12'h000);
        step(); step(); chk_op("opFFF", 16'hABCD, 12'hFFF);
        step(); chk_rd("wr_hi001", 12'h001);

        // Reset during CAP abandons the fetch; start still high refetches 0x200
        step();
        step(); rst_in = 1'b1;
        step();
        chk("rcap_valid", {31'd0, instr_valid}, 32'd0);
        chk("rcap_rden",  {31'd0, mem_rd_en}, 32'd0);
        chk("rcap_addr",  {20'd0, mem_addr}, 32'd0);
        chk("rcap_instr", {16'd0, instr}, 32'd0);
        rst_in = 1'b0;
        step(); chk_rd("re_hi200", 12'h200);
        start = 1'b0;
        step(); step(); step(); chk_op("re_op200", 16'h1234, 12'h200);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
